// File: rtl/bp_trace_pkg.sv
// Shared types for the trace packetizer: FSM states, header layout, default tag.
package bp_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HEADER,
    ST_PAYLOAD
  } state_e;

  typedef struct packed {
    logic [7:0] magic;
    logic [7:0] seq;
    logic [7:0] count;
    logic [7:0] rsvd;
  } pkt_hdr_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hB7;

  function automatic logic [31:0] make_hdr(input logic [7:0] magic,
                                           input logic [7:0] seq,
                                           input logic [7:0] count);
    pkt_hdr_t h;
    h.magic = magic;
    h.seq   = seq;
    h.count = count;
    h.rsvd  = 8'h00;
    return h;
  endfunction

endpackage

// File: rtl/bp_trace_packetizer_if.sv
// 32-bit valid/ready stream with optional last marker, used for both trace input and packet output.
interface bp_trace_packetizer_if;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic        last;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/bp_trace_age_timer.sv
// Packet age counter: cleared when a packet opens, counts while enabled, flags expiry.
module bp_trace_age_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic start,
  input  logic en,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] timer_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      timer_q <= '0;
    end else if (start) begin
      timer_q <= '0;
    end else if (en) begin
      timer_q <= timer_q + TW'(1);
    end
  end

  assign expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bp_trace_packetizer.sv
// Frames the discontinuity-PC stream into header + payload packets for the host DMA.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | buffer empty, waiting for the first word of a packet
// ST_FILL    | collecting words until full, flush or age timeout
// ST_HEADER  | presenting the header beat
// ST_PAYLOAD | presenting buffered words, last beat marked
module bp_trace_packetizer
  import bp_trace_pkg::*;
#(
  parameter int         MAX_WORDS      = 8,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [7:0] MAGIC          = MAGIC_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   flush_i,
  bp_trace_packetizer_if.slave   trace,
  bp_trace_packetizer_if.master  pkt,
  output logic [7:0]             pkt_seq_o
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] rd_idx_q;
  logic [7:0]    seq_q;
  logic          ready_q;
  logic          valid_q;
  logic          last_q;
  logic [31:0]   data_q;
  logic [31:0]   pay_buf [MAX_WORDS];

  logic          hs;
  logic [CW-1:0] next_count;
  logic [CW-1:0] rd_nxt;
  logic          close;
  logic          tmr_start;
  logic          tmr_en;
  logic          tmr_expired;
  logic          unused_trace_last;

  assign unused_trace_last = trace.last;

  always_comb begin
    hs         = trace.valid & ready_q;
    next_count = count_q + CW'(hs);
    rd_nxt     = rd_idx_q + CW'(1);
    close      = (state_q == ST_FILL) &
                 ((next_count == CW'(MAX_WORDS)) | flush_i | tmr_expired);
    tmr_start  = (state_q == ST_IDLE) & hs;
    tmr_en     = (state_q == ST_FILL) & ~close;
  end

  bp_trace_age_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_age_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .start     (tmr_start),
    .en        (tmr_en),
    .expired   (tmr_expired)
  );

  // Buffer is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      pay_buf[IW'(count_q)] <= trace.data;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      rd_idx_q <= '0;
      seq_q    <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (hs) begin
            count_q <= CW'(1);
            if (MAX_WORDS == 1) begin
              state_q <= ST_HEADER;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              last_q  <= 1'b0;
              data_q  <= make_hdr(MAGIC, seq_q, 8'd1);
            end else begin
              state_q <= ST_FILL;
            end
          end
        end

        ST_FILL: begin
          count_q <= next_count;
          if (close) begin
            state_q <= ST_HEADER;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            data_q  <= make_hdr(MAGIC, seq_q, 8'(next_count));
          end
        end

        ST_HEADER: begin
          if (pkt.ready) begin
            state_q  <= ST_PAYLOAD;
            rd_idx_q <= '0;
            data_q   <= pay_buf[0];
            last_q   <= (count_q == CW'(1));
          end
        end

        ST_PAYLOAD: begin
          if (pkt.ready) begin
            if (last_q) begin
              state_q <= ST_IDLE;
              seq_q   <= seq_q + 8'd1;
              count_q <= '0;
              ready_q <= 1'b1;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              data_q  <= '0;
            end else begin
              rd_idx_q <= rd_nxt;
              data_q   <= pay_buf[IW'(rd_nxt)];
              last_q   <= (rd_nxt == count_q - CW'(1));
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign trace.ready = ready_q;
  assign pkt.valid   = valid_q;
  assign pkt.last    = last_q;
  assign pkt.data    = data_q;
  assign pkt_seq_o   = seq_q;

endmodule

// File: tb/tb_bp_trace_packetizer.sv
// Randomized bench for the trace packetizer against a packet-level expectation queue.
module tb_bp_trace_packetizer;

  localparam int MAX_WORDS = 8;
  localparam int TIMEOUT   = 64;

  logic       clk_i     = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       flush_i   = 1'b0;
  logic [7:0] pkt_seq_o;

  bp_trace_packetizer_if tr ();
  bp_trace_packetizer_if pkt ();

  logic ready_rand = 1'b0;
  logic ready_val  = 1'b1;
  logic rnd_bit    = 1'b1;

  assign pkt.ready = ready_rand ? rnd_bit : ready_val;

  bp_trace_packetizer #(
    .MAX_WORDS      (MAX_WORDS),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .flush_i   (flush_i),
    .trace     (tr),
    .pkt       (pkt),
    .pkt_seq_o (pkt_seq_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #1;
    rnd_bit = 1'($urandom);
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packet-level model: every expected beat as {last, data}, in order.
  logic [32:0] exp_q[$];
  logic [31:0] cur_words[$];
  int          model_seq = 0;

  function automatic logic [31:0] hdr(input int seq, input int n);
    return {8'hB7, 8'(seq), 8'(n), 8'h00};
  endfunction

  task automatic expect_pkt();
    exp_q.push_back({1'b0, hdr(model_seq, cur_words.size())});
    foreach (cur_words[i]) exp_q.push_back({(i == cur_words.size() - 1), cur_words[i]});
    model_seq = (model_seq + 1) % 256;
  endtask

  logic        stall_prev = 1'b0;
  logic [31:0] data_prev;
  logic        last_prev;
  logic [32:0] mon_e;

  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_val("hold_valid", 32'(pkt.valid), 32'd1);
        check_val("hold_data", pkt.data, data_prev);
        check_val("hold_last", 32'(pkt.last), 32'(last_prev));
      end
      if (pkt.valid) check_val("in_ready_low", 32'(tr.ready), 32'd0);
      if (pkt.valid && pkt.ready) begin
        check_val("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_val("beat_data", pkt.data, mon_e[31:0]);
          check_val("beat_last", 32'(pkt.last), 32'(mon_e[32]));
        end
      end
      stall_prev = pkt.valid && !pkt.ready;
      data_prev  = pkt.data;
      last_prev  = pkt.last;
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    @(negedge clk_i);
    tr.data  = w;
    tr.valid = 1'b1;
    while (!tr.ready && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check_val("in_ready_wait", 32'(n < 200), 32'd1);
    if (n < 200) @(posedge clk_i);
    #1;
    tr.valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk_i);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_valid", 32'(pkt.valid), 32'd0);
    check_val("rst_last", 32'(pkt.last), 32'd0);
    check_val("rst_data", pkt.data, 32'd0);
    check_val("rst_in_ready", 32'(tr.ready), 32'd0);
    check_val("rst_seq", 32'(pkt_seq_o), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    reset_n_i = 1'b0;
    tr.valid  = 1'b0;
    flush_i   = 1'b0;
    exp_q.delete();
    model_seq = 0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    int          k;
    int          s;
    int          len;
    bit          use_tmo;
    logic [31:0] w1;

    tr.data  = '0;
    tr.valid = 1'b0;
    tr.last  = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_val("idle_in_ready", 32'(tr.ready), 32'd1);

    // Full packet of 8 back-to-back words
    cur_words.delete();
    for (int i = 0; i < 8; i++) begin
      cur_words.push_back(32'h1000 + 32'(4 * i));
      send_word(cur_words[i]);
      if (i == 6) check_val("full_ready_7", 32'(tr.ready), 32'd1);
    end
    expect_pkt();
    check_val("full_ready_8", 32'(tr.ready), 32'd0);
    check_val("full_hdr_now", pkt.data, 32'hB700_0800);
    wait_drain();
    check_val("full_seq", 32'(pkt_seq_o), 32'd1);

    // Single word closed by the age timeout
    cur_words.delete();
    cur_words.push_back(32'h2000);
    send_word(32'h2000);
    expect_pkt();
    check_val("tmo_not_yet", 32'(pkt.valid), 32'd0);
    k = 0;
    do begin
      @(posedge clk_i);
      #1;
      k++;
    end while (!pkt.valid && k < 200);
    check_val("tmo_edges", 32'(k), 32'(TIMEOUT));
    check_val("tmo_hdr", pkt.data, hdr(1, 1));
    wait_drain();

    // Three words then flush; flush in IDLE is ignored
    cur_words.delete();
    for (int i = 0; i < 3; i++) cur_words.push_back($urandom);
    foreach (cur_words[i]) send_word(cur_words[i]);
    s = model_seq;
    expect_pkt();
    do_flush();
    check_val("flush_valid", 32'(pkt.valid), 32'd1);
    check_val("flush_hdr", pkt.data, hdr(s, 3));
    wait_drain();
    do_flush();
    repeat (5) @(negedge clk_i);
    check_val("idle_flush_valid", 32'(pkt.valid), 32'd0);
    check_val("idle_flush_seq", 32'(pkt_seq_o), 32'(model_seq));

    // Backpressure on 5-word packets
    ready_rand = 1'b1;
    for (int p = 0; p < 3; p++) begin
      cur_words.delete();
      for (int i = 0; i < 5; i++) cur_words.push_back($urandom);
      foreach (cur_words[i]) send_word(cur_words[i]);
      expect_pkt();
      do_flush();
      wait_drain();
      check_val("bp_seq", 32'(pkt_seq_o), 32'(model_seq));
    end

    // Random lengths, gaps, close causes and backpressure
    for (int p = 0; p < 30; p++) begin
      len     = $urandom_range(1, MAX_WORDS);
      use_tmo = ($urandom_range(0, 3) == 0);
      cur_words.delete();
      for (int i = 0; i < len; i++) cur_words.push_back($urandom);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
        send_word(cur_words[i]);
      end
      expect_pkt();
      if (len < MAX_WORDS && !use_tmo) do_flush();
      wait_drain();
      check_val("rnd_seq", 32'(pkt_seq_o), 32'(model_seq));
    end
    ready_rand = 1'b0;

    // Sequence number wrap over 257 single-word packets
    apply_reset();
    for (int p = 0; p < 257; p++) begin
      cur_words.delete();
      cur_words.push_back($urandom);
      send_word(cur_words[0]);
      expect_pkt();
      do_flush();
      wait_drain();
      check_val("wrap_seq", 32'(pkt_seq_o), 32'(model_seq));
    end
    check_val("wrap_final", 32'(pkt_seq_o), 32'd1);

    // Reset in the middle of the payload
    @(posedge clk_i);
    #1;
    ready_val = 1'b0;
    cur_words.delete();
    for (int i = 0; i < 4; i++) cur_words.push_back($urandom);
    w1 = cur_words[1];
    foreach (cur_words[i]) send_word(cur_words[i]);
    expect_pkt();
    do_flush();
    ready_val = 1'b1;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    ready_val = 1'b0;
    check_val("pre_rst_data", pkt.data, w1);
    @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    model_seq = 0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    ready_val = 1'b1;
    cur_words.delete();
    for (int i = 0; i < 2; i++) cur_words.push_back($urandom);
    foreach (cur_words[i]) send_word(cur_words[i]);
    expect_pkt();
    do_flush();
    check_val("post_rst_hdr", pkt.data, hdr(0, 2));
    wait_drain();
    check_val("post_rst_seq", 32'(pkt_seq_o), 32'd1);

    repeat (3) @(negedge clk_i);
    check_val("end_queue", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
